// File: rtl/fifo_if_pkg.sv
// Shared types and sizing helpers for the FIFO drain/echo block.
package fifo_if_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 16;

  // Pointer width for the default buffer depth.
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

  typedef logic [WIDTH_DEF-1:0] data_t;

  // Pull-side flow-control state.
  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  // Pointer width for a power-of-2 depth (never below 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_buf.sv
// Small circular buffer holding words pulled from upstream until heard accepts them.
module fifo_drain_buf
  import fifo_if_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int OW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  // Push is refused when full even if a pop happens in the same cycle;
  // clear suppresses both sides.
  assign full    = (occ == OW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are only read while occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_echo.sv
// Pulls words from an upstream FIFO (first/deq) and re-issues them on heard(v),
// with pause/resume, flush and a delivered-word counter.
//
// Handshake: a method call happens on a cycle where its __ENA is high; an
// upstream deq is only issued when fifo_first__RDY and fifo_deq__RDY are both
// high, and a heard word is consumed on a cycle with heard__ENA & heard__RDY.
module fifo_drain_echo
  import fifo_if_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] fifo_first,
  input  logic             fifo_first__RDY,
  input  logic             fifo_deq__RDY,
  output logic             fifo_deq__ENA,
  output logic             heard__ENA,
  output logic [WIDTH-1:0] heard_v,
  input  logic             heard__RDY,
  input  logic             pause__ENA,
  input  logic             resume__ENA,
  input  logic             flush__ENA,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             state_dbg
);

  state_t state;
  state_t state_next;
  logic   full;
  logic   empty;
  logic   pop;

  // Upstream pull is gated by RST directly so it drops the moment reset rises.
  assign fifo_deq__ENA = fifo_first__RDY & fifo_deq__RDY & (state == RUN) &
                         ~full & ~flush__ENA & ~RST;
  assign heard__ENA    = ~empty & ~flush__ENA;
  assign pop           = heard__ENA & heard__RDY;
  assign busy          = ~empty;
  assign state_dbg     = state;

  fifo_drain_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_deq__ENA),
    .pop   (pop),
    .clear (flush__ENA),
    .wdata (fifo_first),
    .head  (heard_v),
    .full  (full),
    .empty (empty)
  );

  // Flow-control state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_next;
  end

  // Pause/resume transitions; simultaneous requests cancel out.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (pause__ENA && !resume__ENA) state_next = PAUSED;
      PAUSED:  if (resume__ENA && !pause__ENA) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Delivered-word counter, wraps freely.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      count <= '0;
    else if (pop) count <= count + CNT_W'(1);
  end

endmodule

// File: doc/fifo_drain_echo.md
Name: fifo_drain_echo

Overview:
- Reader-side counterpart of the l_class_OC_Fifo method interface (enq/deq/first with __ENA/__RDY).
- Acts as the caller of an upstream FIFO's first/deq methods. Pulls words into a small local buffer and re-issues each one on a heard(v) indication method toward a downstream consumer.
- Sits between a request FIFO and the indication path of the echo test. Provides pause/resume flow control, flush, and a delivered-word counter.

Parameters:
- WIDTH, 32, data width of first/heard_v.
- DEPTH, 2, local buffer entries; power of 2, at least 2.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- fifo_first  in  WIDTH  head value from upstream FIFO.
- fifo_first__RDY  in  1  fifo_first is valid.
- fifo_deq__RDY  in  1  upstream deq may be called.
- fifo_deq__ENA  out  1  deq call (pop upstream this cycle).
- heard__ENA  out  1  indication call valid.
- heard_v  out  WIDTH  indication payload.
- heard__RDY  in  1  downstream accepts heard this cycle.
- pause__ENA  in  1  stop pulling from upstream.
- resume__ENA  in  1  restart pulling.
- flush__ENA  in  1  discard local buffer contents.
- count  out  CNT_W  words delivered via heard since reset.
- busy  out  1  buffer non-empty.

Behaviour:
- Interface decision: one clock, CLK. Reset RST is asynchronous and active-high.
- All state clears on RST assertion, independent of CLK. Reset state:
  - FSM = RUN; buffer empty (rd_ptr = wr_ptr = 0, occupancy 0); count = 0.
  - Combinational outputs under reset: fifo_deq__ENA = 0, heard__ENA = 0, heard_v = 0, busy = 0.
- FSM states:
  - RUN to PAUSED on pause__ENA & !resume__ENA.
  - PAUSED to RUN on resume__ENA & !pause__ENA.
  - Both asserted together: no state change.
- Pull rule (combinational):
  - fifo_deq__ENA = fifo_first__RDY & fifo_deq__RDY & (state == RUN) & !full & !flush__ENA & !RST.
  - When fifo_deq__ENA is high, fifo_first is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Deliver rule (combinational):
  - heard__ENA = !empty & !flush__ENA.
  - heard_v = buffer[rd_ptr] when !empty, else 0.
  - On heard__ENA & heard__RDY: rd_ptr increments modulo DEPTH and count increments.
- Latency: a word dequeued in cycle N is presented on heard in cycle N+1 at the earliest. There is no combinational bypass from fifo_first to heard_v.
- Full/empty: occupancy counter 0..DEPTH.
  - full = (occupancy == DEPTH). Push is blocked when full, even if a pop happens in the same cycle.
  - Push and pop in the same non-full, non-empty cycle leave occupancy unchanged.
- Flush:
  - On a cycle with flush__ENA, occupancy and both pointers go to 0 at the next edge.
  - No push, no pop, and no count change in that cycle. FSM state is unaffected.
- PAUSED state: the buffer still drains to heard; only upstream pulls stop.
- count: wraps from 2^CNT_W-1 to 0. No saturation.
- busy = !empty.
- Reset mid-transfer: buffered words are lost. fifo_deq__ENA drops immediately with RST.

Decomposition:
- Shared package fifo_if_pkg:
  - state enum {RUN, PAUSED};
  - data_t (WIDTH-bit) typedef;
  - ptr width constant $clog2(DEPTH).
- One natural sub-module: fifo_drain_buf. It holds the DEPTH-entry storage, the pointers and the occupancy, and exposes push/pop/full/empty/head.
- FSM, handshake gating and counter stay in the top module.

Test Plan:
- Basic stream: upstream presents 0x11, 0x22, 0x33 with both RDYs high and heard__RDY = 1.
  - fifo_deq__ENA asserts in cycles 0..2.
  - heard__ENA asserts in cycles 1..3 with heard_v = 0x11, 0x22, 0x33.
  - count = 3.
- Backpressure: heard__RDY = 0 and upstream holds 4 words, DEPTH = 2.
  - Exactly 2 deq calls, then fifo_deq__ENA = 0 and busy = 1.
  - Raising heard__RDY delivers 0x…1, 0x…2 in order, and pulls resume once the buffer is no longer full.
- Pause/resume: pause__ENA pulsed with 1 word buffered.
  - That word is still delivered on heard.
  - No deq until resume__ENA.
  - Pause and resume asserted in the same cycle leave the state unchanged.
- Flush: 2 words buffered, then flush__ENA for 1 cycle.
  - heard__ENA = 0 and fifo_deq__ENA = 0 in the flush cycle.
  - Next cycle busy = 0 and count is unchanged.
- Counter wrap with CNT_W = 4: deliver 17 words → count = 1.
- Async reset: assert RST between clock edges mid-stream.
  - Outputs drop immediately: fifo_deq__ENA = 0, heard__ENA = 0, count = 0.
  - After release, streaming restarts from an empty buffer in RUN.
